// File: rtl/ufpgapll_pkg.sv
// Shared constants for the PLL board: system clock, frequency-counter width
// and the legal output frequency range shared with the NCO block.
package ufpgapll_pkg;

    localparam int unsigned SYS_CLK_HZ   = 50_000_000;
    localparam int unsigned FREQ_CNT_W   = 20;

    localparam int unsigned FREQ_MIN     = 1_000;
    localparam int unsigned FREQ_DEFAULT = 100_000;
    localparam int unsigned FREQ_MAX     = 400_000;

endpackage

// File: rtl/freq_counter_if.sv
// Measurement bus of the frequency counter: the signal to measure, the
// window restart, and the published result with its status flags.
// The master side feeds the signal and reads results; the slave is the counter.
interface freq_counter_if import ufpgapll_pkg::*; #(
    parameter int CNT_W = FREQ_CNT_W
);
    logic             sig_in;
    logic             clr;
    logic [CNT_W-1:0] freq;
    logic             freq_valid;
    logic             overflow;
    logic             nosig;

    modport master (
        output sig_in, clr,
        input  freq, freq_valid, overflow, nosig
    );

    modport slave (
        input  sig_in, clr,
        output freq, freq_valid, overflow, nosig
    );
endinterface

// File: rtl/freq_counter_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for an
// asynchronous input. Detection is masked for the first two cycles after
// reset so that an input already high at reset release gives no edge.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic       s1;
    logic       s2;
    logic       rise_q;
    logic [1:0] prime_ctr;
    logic       primed;

    assign primed = (prime_ctr == 2'd2);
    assign rise   = rise_q;

    // Synchronize, register the rise, and count off the priming cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            rise_q    <= 1'b0;
            prime_ctr <= 2'd0;
        end else begin
            s1     <= d;
            s2     <= s1;
            rise_q <= s1 & ~s2 & primed;
            if (!primed) begin
                prime_ctr <= prime_ctr + 2'd1;
            end
        end
    end
endmodule

// File: rtl/freq_counter.sv
// Gated frequency counter: counts rising edges of an asynchronous input over
// a window of GATE_CYCLES clocks and publishes the saturated count, an
// overflow flag and a no-signal flag at the end of every window.
// GATE_CYCLES must be at least 4.
module freq_counter import ufpgapll_pkg::*; #(
    parameter int GATE_CYCLES = SYS_CLK_HZ,
    parameter int CNT_W       = FREQ_CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    freq_counter_if.slave bus
);
    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic              rise;
    logic [GATE_W-1:0] gate_ctr;
    logic [CNT_W-1:0]  edge_ctr;
    logic              sat;
    logic              window_end;
    logic              edge_lost;
    logic              publish;
    logic [CNT_W-1:0]  final_count;
    logic              final_sat;

    logic [CNT_W-1:0]  freq_q;
    logic              freq_valid_q;
    logic              overflow_q;
    logic              nosig_q;

    sync_edge u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.sig_in),
        .rise  (rise)
    );

    // Count including an edge detected this cycle; an edge arriving at full scale is lost and flags saturation.
    always_comb begin
        window_end  = (gate_ctr == GATE_LAST);
        publish     = window_end & ~bus.clr;
        edge_lost   = rise & (edge_ctr == CNT_MAX);
        final_count = edge_ctr;
        if (rise && !edge_lost) begin
            final_count = edge_ctr + CNT_W'(1);
        end
        final_sat   = sat | edge_lost;
    end

    // Gate counter runs 0..GATE_CYCLES-1 and restarts on wrap or clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_ctr <= '0;
        end else if (bus.clr || window_end) begin
            gate_ctr <= '0;
        end else begin
            gate_ctr <= gate_ctr + GATE_W'(1);
        end
    end

    // Edge counter and saturation flag restart at every window boundary and on clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_ctr <= '0;
            sat      <= 1'b0;
        end else if (bus.clr || window_end) begin
            edge_ctr <= '0;
            sat      <= 1'b0;
        end else begin
            edge_ctr <= final_count;
            sat      <= final_sat;
        end
    end

    // Publish the closing window's result unless clr cancels it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_q       <= '0;
            freq_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            nosig_q      <= 1'b1;
        end else begin
            freq_valid_q <= publish;
            if (publish) begin
                freq_q     <= final_count;
                overflow_q <= final_sat;
                nosig_q    <= (final_count == '0);
            end
        end
    end

    assign bus.freq       = freq_q;
    assign bus.freq_valid = freq_valid_q;
    assign bus.overflow   = overflow_q;
    assign bus.nosig      = nosig_q;
endmodule

// File: tb/tb_freq_counter.sv
// Testbench for freq_counter with a 1000-cycle gate. Two instances: a 20-bit
// counter for the nominal, boundary, clr and reset cases, and a 6-bit counter
// for saturation. Stimulus pushes expected results into per-instance queues
// and monitors pop them whenever freq_valid pulses.
module tb_freq_counter;
    localparam int GATE = 1000;

    typedef enum {PAT_LOW, PAT_HIGH, PAT_CLOCK, PAT_STEP} pat_e;

    typedef struct {
        int freq;
        bit ovf;
        bit nosig;
    } exp_t;

    logic clk;
    logic rst_n_a;
    logic rst_n_b;

    int   checks;
    int   errors;
    bit   b_done;
    exp_t q_a[$];
    exp_t q_b[$];

    freq_counter_if #(.CNT_W(20)) bus_a ();
    freq_counter_if #(.CNT_W(6))  bus_b ();

    freq_counter #(.GATE_CYCLES(GATE), .CNT_W(20)) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (bus_a)
    );

    freq_counter #(.GATE_CYCLES(GATE), .CNT_W(6)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (bus_b)
    );

    // 100 MHz-style bench clock; only the cycle count matters.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #(20_000 * 10);
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic pat_val(input pat_e kind, input int p, input int ph, input int c);
        case (kind)
            PAT_LOW:   return 1'b0;
            PAT_HIGH:  return 1'b1;
            PAT_CLOCK: return ((c + p - ph) % p) < (p / 2);
            PAT_STEP:  return c >= ph;
            default:   return 1'b0;
        endcase
    endfunction

    // Drives one gate window cycle by cycle, starting 1 time unit after the
    // edge that opens gate cycle 0. Returns early at abort_at (caller then
    // applies clr or reset in that cycle). hold_freq >= 0 also checks that the
    // old result is still held in the last gate cycle and that freq_valid
    // arrives right after it.
    task automatic apply_stimulus(input bit on_b, input pat_e kind, input int p, input int ph,
                                  input int abort_at, input int hold_freq,
                                  input int exp_freq, input bit exp_ovf, input bit exp_nosig);
        exp_t e;
        e.freq  = exp_freq;
        e.ovf   = exp_ovf;
        e.nosig = exp_nosig;
        for (int c = 0; c < GATE; c++) begin
            if (on_b) bus_b.sig_in = pat_val(kind, p, ph, c);
            else      bus_a.sig_in = pat_val(kind, p, ph, c);
            if (c == abort_at) return;
            if (c == GATE - 1) begin
                if (on_b) q_b.push_back(e);
                else      q_a.push_back(e);
                if (hold_freq >= 0) begin
                    check_output("a_valid_before_first_result", int'(bus_a.freq_valid), 0);
                    check_output("a_freq_held_until_result", int'(bus_a.freq), hold_freq);
                end
            end
            @(posedge clk);
            #1;
        end
        if (hold_freq >= 0) begin
            check_output("a_valid_first_result_timing", int'(bus_a.freq_valid), 1);
        end
    endtask

    // Scoreboard for the 20-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (bus_a.freq_valid === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL a_unexpected_valid: got pulse with freq=%0d required no pulse at %0t",
                         bus_a.freq, $time);
            end else begin
                e = q_a.pop_front();
                check_output("a_freq", int'(bus_a.freq), e.freq);
                check_output("a_overflow", int'(bus_a.overflow), int'(e.ovf));
                check_output("a_nosig", int'(bus_a.nosig), int'(e.nosig));
            end
        end
    end

    // Scoreboard for the 6-bit instance while its script is running.
    always @(negedge clk) begin
        exp_t e;
        if (!b_done && bus_b.freq_valid === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL b_unexpected_valid: got pulse with freq=%0d required no pulse at %0t",
                         bus_b.freq, $time);
            end else begin
                e = q_b.pop_front();
                check_output("b_freq", int'(bus_b.freq), e.freq);
                check_output("b_overflow", int'(bus_b.overflow), int'(e.ovf));
                check_output("b_nosig", int'(bus_b.nosig), int'(e.nosig));
            end
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        b_done       = 1'b0;
        rst_n_a      = 1'b0;
        rst_n_b      = 1'b0;
        bus_a.sig_in = 1'b1;
        bus_a.clr    = 1'b0;
        bus_b.sig_in = 1'b0;
        bus_b.clr    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] checking reset values");
        check_output("a_reset_freq", int'(bus_a.freq), 0);
        check_output("a_reset_valid", int'(bus_a.freq_valid), 0);
        check_output("a_reset_overflow", int'(bus_a.overflow), 0);
        check_output("a_reset_nosig", int'(bus_a.nosig), 1);
        check_output("b_reset_freq", int'(bus_b.freq), 0);
        check_output("b_reset_nosig", int'(bus_b.nosig), 1);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        fork
            begin
                // Input high through reset, then low: no edges at all.
                apply_stimulus(0, PAT_HIGH, 0, 0, -1, -1, 0, 0, 1);
                apply_stimulus(0, PAT_LOW, 0, 0, -1, -1, 0, 0, 1);
                // Period 10, rises at gate cycles 5, 15, ... 995: 100 per window.
                repeat (3) apply_stimulus(0, PAT_CLOCK, 10, 5, -1, -1, 100, 0, 0);
                // Rise driven in cycle 997 is detected in cycle 999: closing window.
                apply_stimulus(0, PAT_STEP, 0, 997, -1, -1, 1, 0, 0);
                // Rise driven in cycle 998 is detected in the next window.
                apply_stimulus(0, PAT_STEP, 0, 998, -1, -1, 0, 0, 1);
                apply_stimulus(0, PAT_LOW, 0, 0, -1, -1, 1, 0, 0);
                // clr halfway through: result from the previous window must hold.
                apply_stimulus(0, PAT_CLOCK, 10, 5, 500, -1, 0, 0, 0);
                bus_a.clr = 1'b1;
                @(posedge clk);
                #1;
                bus_a.clr = 1'b0;
                check_output("a_clr_freq_hold", int'(bus_a.freq), 1);
                check_output("a_clr_nosig_hold", int'(bus_a.nosig), 0);
                check_output("a_clr_no_valid", int'(bus_a.freq_valid), 0);
                apply_stimulus(0, PAT_CLOCK, 10, 5, -1, 1, 100, 0, 0);
                // Reset in the middle of a window clears everything at once.
                apply_stimulus(0, PAT_CLOCK, 10, 5, 300, -1, 0, 0, 0);
                rst_n_a = 1'b0;
                #2;
                check_output("a_midreset_freq", int'(bus_a.freq), 0);
                check_output("a_midreset_nosig", int'(bus_a.nosig), 1);
                check_output("a_midreset_overflow", int'(bus_a.overflow), 0);
                check_output("a_midreset_valid", int'(bus_a.freq_valid), 0);
                repeat (3) @(posedge clk);
                #1;
                rst_n_a = 1'b1;
                // First result lands in the 1001st cycle after release.
                apply_stimulus(0, PAT_CLOCK, 10, 5, -1, 0, 100, 0, 0);
                bus_a.sig_in = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            begin
                // Period 4 gives 250 edges: clamps at 63 with overflow.
                repeat (2) apply_stimulus(1, PAT_CLOCK, 4, 1, -1, -1, 63, 1, 0);
                // Period 40 gives 25 edges: fits, overflow clears.
                repeat (2) apply_stimulus(1, PAT_CLOCK, 40, 20, -1, -1, 25, 0, 0);
                bus_b.sig_in = 1'b0;
                @(negedge clk);
                #1;
                b_done = 1'b1;
            end
        join

        check_output("a_all_results_seen", q_a.size(), 0);
        check_output("b_all_results_seen", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
